uc_pilha: RTL and testbench
===========================

# uc_pilha

Stack control unit for the MIPS datapath. It owns push/pop sequencing against data memory and computes the new stack pointer. The register file holds `$rp` (register 3, reset value 25). This block reads the current `$rp`, performs the memory access, then writes the updated pointer back through `rp`/`PilhaE` for exactly one cycle.

## Interface
- `RP_BASE`, 25: empty-stack pointer value; equals the register file's `$rp` initial value.
- `DEPTH`, 32: maximum number of entries; the stack is full when `rp_in == RP_BASE + DEPTH`.
- `DATA_W`, 32: data and pointer width.
- `clock`  in  1: single clock, rising-edge logic.
- `reset`  in  1: asynchronous, active-high.
- `push`  in  1: push request, sampled only while `pronto=1`.
- `pop`  in  1: pop request, sampled only while `pronto=1`.
- `rp_in`  in  32: current `$rp` from the register file.
- `dado_push`  in  32: value to push (`rs` read port).
- `mem_rdata`  in  32: memory read data.
- `mem_ready`  in  1: memory completes the current access this cycle.
- `pronto`  out  1: idle; requests are accepted.
- `mem_addr`  out  32: memory address.
- `mem_wdata`  out  32: memory write data.
- `mem_we`  out  1: memory write strobe.
- `mem_re`  out  1: memory read strobe.
- `rp`  out  32: new `$rp` value.
- `PilhaE`  out  1: `$rp` write enable. The register file writes on the falling edge.
- `pop_dado`  out  32: popped value.
- `pop_valido`  out  1: `pop_dado` is valid (one-cycle pulse).
- `erro`  out  1: overflow, underflow or conflict (one-cycle pulse).

## Operation
- States: OCIOSO, ESCREVE, LE, ATUALIZA.
- OCIOSO:
  - `pronto=1`.
  - On `push` only, latch `rp_in` to `rp_lat` and `dado_push` to `d_lat`.
  - `push` at full (`rp_in == RP_BASE+DEPTH`): pulse `erro`, stay in OCIOSO, no memory access.
  - `push` otherwise: go to ESCREVE.
  - On `pop` only, latch `rp_in`.
  - `pop` at empty (`rp_in == RP_BASE`): pulse `erro`, stay in OCIOSO.
  - `pop` otherwise: go to LE.
  - `push` and `pop` together: pulse `erro`, no operation.
- ESCREVE:
  - Drive `mem_we=1`, `mem_addr=rp_lat`, `mem_wdata=d_lat`.
  - Hold until `mem_ready=1`, then go to ATUALIZA with `rp_novo = rp_lat + 1`.
- LE:
  - Drive `mem_re=1`, `mem_addr=rp_lat - 1`.
  - On `mem_ready=1`, capture `mem_rdata`, set `rp_novo = rp_lat - 1`, go to ATUALIZA.
- ATUALIZA:
  - Drive `PilhaE=1` and `rp=rp_novo` for one cycle.
  - After a pop, also pulse `pop_valido=1` with `pop_dado` = the captured value.
  - Return to OCIOSO.
- Pointer arithmetic is 32-bit modulo. Wrap-around cannot occur because of the full/empty checks.
- Requests while `pronto=0` are ignored and not queued.
- `$rp` changes only in ATUALIZA. An aborted operation leaves `$rp` untouched.

## Timing
- All outputs are registered or decoded from registered state only. There is no combinational path from inputs to outputs, so `PilhaE`/`rp` are stable at the falling edge.
- Reset values:
  - state OCIOSO, `pronto=1`.
  - `mem_we=mem_re=PilhaE=pop_valido=erro=0`.
  - `rp`, `mem_addr`, `mem_wdata`, `pop_dado` = 0.
- Reset mid-operation drops the memory strobes immediately (asynchronously), abandons the access and issues no `PilhaE`.
- Latency with `mem_ready` tied high:
  - Request sampled at edge t.
  - ESCREVE/LE during cycle t+1.
  - ATUALIZA during t+2 (`PilhaE` high).
  - `pronto=1` again from t+3.
- Each cycle of `mem_ready=0` adds one cycle; strobes and address hold constant during the stall.
- `erro` rises the cycle after the offending request and lasts one cycle; `pronto` stays 1.

## Structure
- Shared package `pilha_pkg`: the state encoding (2-bit, OCIOSO=0, ESCREVE=1, LE=2, ATUALIZA=3), `RP_BASE`, `DEPTH`, `DATA_W`, and `ADDR_RP=3` (register number shared with the register file).
- Single module; no sub-module. The full/empty compare and the ±1 adder are inline.

## Test plan
- Reset asserted mid-cycle → all outputs at reset values immediately; `pronto=1`.
- `push`, `rp_in=25`, `dado_push=0xDEADBEEF`, `mem_ready=1` → t+1: `mem_we=1`, `mem_addr=25`, `mem_wdata=0xDEADBEEF`; t+2: `PilhaE=1`, `rp=26`; t+3: `pronto=1`.
- `pop`, `rp_in=26`, `mem_rdata=0xDEADBEEF` → `mem_re=1`, `mem_addr=25`; then `PilhaE=1`, `rp=25`, `pop_valido=1`, `pop_dado=0xDEADBEEF`.
- `pop` with `rp_in=25`; `push` with `rp_in=57`; `push` and `pop` together → `erro` one-cycle pulse each; no strobes; `PilhaE=0`.
- `push` with `mem_ready` low for 3 cycles → `mem_we`/`mem_addr` held 4 cycles; `PilhaE` the cycle after `mem_ready`; a `pop` pulse during the stall is ignored.
- `reset` asserted during LE → strobes drop; no `PilhaE`; the next `pop` with the same `rp_in` completes normally.

Source files
------------

// File: rtl/pilha_pkg.sv
// Shared definitions for the stack control unit: state encoding, stack geometry
// and the register number of $rp in the register file.
package pilha_pkg;

    localparam int DATA_W = 32;

    localparam logic [DATA_W-1:0] RP_BASE = 32'd25;
    localparam logic [DATA_W-1:0] DEPTH   = 32'd32;
    localparam logic [DATA_W-1:0] RP_FULL = RP_BASE + DEPTH;
    localparam logic [DATA_W-1:0] ONE     = 32'd1;

    localparam logic [4:0] ADDR_RP = 5'd3;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        ESCREVE  = 2'd1,
        LE       = 2'd2,
        ATUALIZA = 2'd3
    } estado_t;

endpackage

// File: rtl/uc_pilha.sv
// Stack control unit: sequences push/pop against data memory and hands the
// updated $rp back to the register file for exactly one cycle.
module uc_pilha
    import pilha_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] rp_in,
    input  logic [DATA_W-1:0] dado_push,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              pronto,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    output logic [DATA_W-1:0] rp,
    output logic              PilhaE,
    output logic [DATA_W-1:0] pop_dado,
    output logic              pop_valido,
    output logic              erro,
    output estado_t           estado
);

    // Handshake: push/pop are taken only on a rising edge where pronto=1;
    // a memory access is held (strobe, address, data) until mem_ready=1 is
    // seen on a rising edge, which completes it in that same cycle.
    logic [DATA_W-1:0] rp_lat;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado     <= OCIOSO;
            pronto     <= 1'b1;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            PilhaE     <= 1'b0;
            pop_valido <= 1'b0;
            erro       <= 1'b0;
            rp         <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            pop_dado   <= '0;
            rp_lat     <= '0;
        end else begin
            PilhaE     <= 1'b0;
            pop_valido <= 1'b0;
            erro       <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (push && pop) begin
                        erro <= 1'b1;
                    end else if (push) begin
                        if (rp_in == RP_FULL) begin
                            erro <= 1'b1;
                        end else begin
                            rp_lat    <= rp_in;
                            mem_addr  <= rp_in;
                            mem_wdata <= dado_push;
                            mem_we    <= 1'b1;
                            pronto    <= 1'b0;
                            estado    <= ESCREVE;
                        end
                    end else if (pop) begin
                        if (rp_in == RP_BASE) begin
                            erro <= 1'b1;
                        end else begin
                            rp_lat   <= rp_in;
                            mem_addr <= rp_in - ONE;
                            mem_re   <= 1'b1;
                            pronto   <= 1'b0;
                            estado   <= LE;
                        end
                    end
                end
                ESCREVE: begin
                    if (mem_ready) begin
                        mem_we <= 1'b0;
                        rp     <= rp_lat + ONE;
                        PilhaE <= 1'b1;
                        estado <= ATUALIZA;
                    end
                end
                LE: begin
                    if (mem_ready) begin
                        mem_re     <= 1'b0;
                        pop_dado   <= mem_rdata;
                        pop_valido <= 1'b1;
                        rp         <= rp_lat - ONE;
                        PilhaE     <= 1'b1;
                        estado     <= ATUALIZA;
                    end
                end
                ATUALIZA: begin
                    pronto <= 1'b1;
                    estado <= OCIOSO;
                end
                default: begin
                    pronto <= 1'b1;
                    estado <= OCIOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uc_pilha.sv
// Bench for uc_pilha: directed latency/error/stall/reset scenarios followed by
// random push/pop traffic checked against a stack-depth reference model.
module tb_uc_pilha;
    import pilha_pkg::*;

    localparam int EXP_W = 2 + DATA_W + DATA_W;
    localparam logic [1:0] K_ERR  = 2'd0;
    localparam logic [1:0] K_PUSH = 2'd1;
    localparam logic [1:0] K_POP  = 2'd2;

    logic              clock, reset, push, pop, mem_ready;
    logic [DATA_W-1:0] rp_in, dado_push, mem_rdata;
    logic              pronto, mem_we, mem_re, PilhaE, pop_valido, erro;
    logic [DATA_W-1:0] mem_addr, mem_wdata, rp, pop_dado;
    estado_t           estado;

    logic [DATA_W-1:0] mem [256];
    logic [DATA_W-1:0] rp_reg = 32'd25;
    logic [DATA_W-1:0] rp_ovr;
    logic              rp_ovr_en, rand_ready, ready_fix, ready_rnd;

    int checks = 0;
    int errors = 0;
    logic [EXP_W-1:0]  exp_q[$];
    logic [DATA_W-1:0] ref_stack[$];

    uc_pilha dut (
        .clock(clock), .reset(reset), .push(push), .pop(pop),
        .rp_in(rp_in), .dado_push(dado_push), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .pronto(pronto), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re), .rp(rp),
        .PilhaE(PilhaE), .pop_dado(pop_dado), .pop_valido(pop_valido),
        .erro(erro), .estado(estado)
    );

    // clock / environment (register file on falling edge, data memory)
    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign rp_in     = rp_ovr_en ? rp_ovr : rp_reg;
    assign mem_ready = rand_ready ? ready_rnd : ready_fix;
    assign mem_rdata = mem[mem_addr[7:0]];

    always @(negedge clock) ready_rnd <= ($urandom_range(0, 3) != 0);
    always @(negedge clock) if (PilhaE) rp_reg <= rp;
    always @(posedge clock) if (mem_we && mem_ready) mem[mem_addr[7:0]] <= mem_wdata;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    // reference model: a plain stack; $rp is the base plus the entry count
    task automatic model(input bit p, input bit q, input logic [DATA_W-1:0] d, input bit force_err);
        logic [DATA_W-1:0] n;
        if (!p && !q) return;
        if (force_err || (p && q)) begin
            exp_q.push_back({K_ERR, 32'd0, 32'd0});
        end else if (p) begin
            if (ref_stack.size() >= int'(DEPTH)) begin
                exp_q.push_back({K_ERR, 32'd0, 32'd0});
            end else begin
                ref_stack.push_back(d);
                n = ref_stack.size();
                exp_q.push_back({K_PUSH, RP_BASE + n, 32'd0});
            end
        end else begin
            if (ref_stack.size() == 0) begin
                exp_q.push_back({K_ERR, 32'd0, 32'd0});
            end else begin
                d = ref_stack.pop_back();
                n = ref_stack.size();
                exp_q.push_back({K_POP, RP_BASE + n, d});
            end
        end
    endtask

    task automatic issue(input bit p, input bit q, input logic [DATA_W-1:0] d, input bit force_err);
        push = p;
        pop = q;
        dado_push = d;
        model(p, q, d, force_err);
        step();
        push = 1'b0;
        pop = 1'b0;
    endtask

    task automatic monitor();
        logic [EXP_W-1:0]  e;
        logic [1:0]        ek, gk;
        logic [DATA_W-1:0] er, ed;
        forever begin
            @(negedge clock);
            if (pop_valido) begin
                checks++;
                if (!PilhaE) begin
                    errors++;
                    $display("FAIL pop_valido_without_PilhaE: got PilhaE=0 required 1");
                end
            end
            if (erro || PilhaE) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_unexpected: erro=%0b PilhaE=%0b rp=%0d with no response expected",
                             erro, PilhaE, rp);
                end else begin
                    e  = exp_q.pop_front();
                    ek = e[EXP_W-1 -: 2];
                    er = e[2*DATA_W-1 -: DATA_W];
                    ed = e[DATA_W-1:0];
                    gk = erro ? K_ERR : (pop_valido ? K_POP : K_PUSH);
                    if (gk != ek || (erro && PilhaE) || (ek != K_ERR && rp != er) ||
                        (ek == K_POP && pop_dado != ed)) begin
                        errors++;
                        $display("FAIL scoreboard: got kind=%0d rp=%0d dado=0x%h required kind=%0d rp=%0d dado=0x%h",
                                 gk, rp, pop_dado, ek, er, ed);
                    end
                end
            end
        end
    endtask

    task automatic err_checks(input string name);
        check({name, "_erro"}, erro, 1);
        check({name, "_strobes"}, {mem_we, mem_re}, 0);
        check({name, "_PilhaE"}, PilhaE, 0);
        check({name, "_pronto"}, pronto, 1);
        step();
        check({name, "_erro_width"}, erro, 0);
    endtask

    initial begin
        int r, w, push_pct;
        reset = 1'b1;
        push = 1'b0;
        pop = 1'b0;
        dado_push = '0;
        rp_ovr = '0;
        rp_ovr_en = 1'b0;
        rand_ready = 1'b0;
        ready_fix = 1'b1;
        fork
            monitor();
        join_none

        // reset values
        #12;
        check("rst_pronto", pronto, 1);
        check("rst_strobes", {mem_we, mem_re, PilhaE, pop_valido, erro}, 0);
        check("rst_rp", rp, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_pop_dado", pop_dado, 0);
        check("rst_estado", {30'd0, estado}, {30'd0, OCIOSO});
        step();
        reset = 1'b0;
        step();

        // push latency with mem_ready high
        issue(1, 0, 32'hDEADBEEF, 0);
        check("push_we", mem_we, 1);
        check("push_addr", mem_addr, 25);
        check("push_wdata", mem_wdata, 32'hDEADBEEF);
        check("push_busy", pronto, 0);
        step();
        check("push_PilhaE", PilhaE, 1);
        check("push_rp", rp, 26);
        step();
        check("push_pronto", pronto, 1);

        // pop latency
        issue(0, 1, 0, 0);
        check("pop_re", mem_re, 1);
        check("pop_addr", mem_addr, 25);
        step();
        check("pop_PilhaE", PilhaE, 1);
        check("pop_rp", rp, 25);
        check("pop_valido", pop_valido, 1);
        check("pop_dado", pop_dado, 32'hDEADBEEF);
        step();
        check("pop_pronto", pronto, 1);

        // error cases: empty pop, full push, simultaneous request
        issue(0, 1, 0, 0);
        err_checks("underflow");
        rp_ovr = 32'd57;
        rp_ovr_en = 1'b1;
        issue(1, 0, 32'h1111_2222, 1);
        rp_ovr_en = 1'b0;
        err_checks("overflow");
        issue(1, 1, 32'h3333_4444, 0);
        err_checks("conflict");

        // push with three stall cycles and an ignored pop pulse
        ready_fix = 1'b0;
        issue(1, 0, 32'h1234_5678, 0);
        for (int i = 0; i < 4; i++) begin
            check("stall_we", mem_we, 1);
            check("stall_addr", mem_addr, 25);
            check("stall_wdata", mem_wdata, 32'h1234_5678);
            check("stall_no_PilhaE", PilhaE, 0);
            if (i == 1) pop = 1'b1;
            if (i == 2) pop = 1'b0;
            if (i == 3) ready_fix = 1'b1;
            step();
        end
        check("stall_PilhaE", PilhaE, 1);
        check("stall_rp", rp, 26);
        step();
        check("stall_pronto", pronto, 1);

        // reset during LE abandons the pop
        ready_fix = 1'b0;
        pop = 1'b1;
        step();
        pop = 1'b0;
        check("abort_re", mem_re, 1);
        check("abort_addr", mem_addr, 25);
        #2 reset = 1'b1;
        #1;
        check("abort_strobes", {mem_we, mem_re, PilhaE}, 0);
        check("abort_pronto", pronto, 1);
        step();
        reset = 1'b0;
        ready_fix = 1'b1;
        step();
        step();
        issue(0, 1, 0, 0);
        check("retry_addr", mem_addr, 25);
        step();
        check("retry_PilhaE", PilhaE, 1);
        check("retry_dado", pop_dado, 32'h1234_5678);
        step();

        // random traffic: fill towards full, drain towards empty, then mixed
        rand_ready = 1'b1;
        for (int ph = 0; ph < 3; ph++) begin
            push_pct = (ph == 0) ? 82 : ((ph == 1) ? 12 : 48);
            for (int n = 0; n < 150; n++) begin
                w = 0;
                while (!pronto && w < 40) begin
                    step();
                    w++;
                end
                if (!pronto) begin
                    checks++;
                    errors++;
                    $display("FAIL pronto_timeout: got pronto=0 required 1 within 40 cycles");
                end else begin
                    r = $urandom_range(0, 99);
                    if (r < 4) issue(1, 1, $urandom, 0);
                    else if (r < 4 + push_pct) issue(1, 0, $urandom, 0);
                    else issue(0, 1, 0, 0);
                end
            end
        end

        repeat (20) step();
        check("exp_q_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
